frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter WORD_W, default 100, width of one output word in bits.
REQ-002 Parameter NWORDS, default 10, words per frame, SHALL be >= 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer presents a frame on in_frame.
REQ-006 in_ready  output  1  block accepts a frame this cycle when high.
REQ-007 in_frame  input  WORD_W*NWORDS  frame; word k occupies bits [(NWORDS-k)*WORD_W-1 : (NWORDS-1-k)*WORD_W], word 0 most significant.
REQ-008 out_valid  output  1  out_word holds a valid word.
REQ-009 out_ready  input  1  consumer takes out_word this cycle when high.
REQ-010 out_word  output  WORD_W  current word, descaled.
REQ-011 out_last  output  1  high with out_valid on word NWORDS-1 of a frame.
REQ-012 busy  output  1  high while any word of a held frame is not yet transferred.

Function
REQ-013 A frame transfer occurs on a rising edge with in_valid && in_ready; an output transfer occurs on a rising edge with out_valid && out_ready.
REQ-014 States: IDLE (no frame held) and SEND (frame held, index idx in 0..NWORDS-1).
REQ-015 IDLE: in_ready=1, out_valid=0, busy=0; on a frame transfer, latch in_frame, set idx=0, go to SEND.
REQ-016 SEND: out_valid=1, busy=1, out_word = word idx of the held frame, logically shifted right by 1 (MSB forced to 0), undoing the upstream x2 scaling modulo 2^WORD_W.
REQ-017 out_last=1 exactly when state=SEND and idx=NWORDS-1; otherwise 0.
REQ-018 SEND, output transfer with idx<NWORDS-1: idx increments by 1; the held frame is unchanged.
REQ-019 SEND, idx<NWORDS-1: in_ready=0; in_frame is ignored.
REQ-020 SEND, idx=NWORDS-1: in_ready=out_ready (combinational pass-through), so the next frame can be taken back-to-back.
REQ-021 SEND, idx=NWORDS-1, output transfer plus frame transfer in the same cycle: latch the new frame, idx=0, stay in SEND; no bubble on out_valid.
REQ-022 SEND, idx=NWORDS-1, output transfer and no frame transfer: go to IDLE.
REQ-023 SEND, out_ready=0: idx, held frame, out_word, out_valid and out_last are all held stable.
REQ-024 Latency: the first word is valid in the cycle after the frame transfer; with out_ready held at 1, a frame drains in exactly NWORDS cycles.
REQ-025 Throughput: with in_valid and out_ready continuously high, out_valid stays 1 indefinitely, i.e. one word per cycle.
REQ-026 idx is a counter of width clog2(NWORDS); it never exceeds NWORDS-1.
REQ-027 No combinational path exists from in_frame to any output; out_word depends only on registered state.

Reset
REQ-028 While rst=1, or at its assertion in any state including mid-frame: state=IDLE, idx=0, held frame=0, out_valid=0, out_last=0, busy=0, in_ready=1.
REQ-029 A partially sent frame is discarded on reset and is not resumed.
REQ-030 The first frame transfer can occur on the first rising edge after rst deasserts.

Verification
REQ-031 Single frame: WORD_W=100, NWORDS=10, word k = 2*(k+1), out_ready=1 -> out_word = 1,2,...,10 on consecutive cycles, out_last only on 10, then IDLE.
REQ-032 Wrap-around descale: word 0 = 2^99 + 6 -> out_word = 2^98 + 3, MSB=0.
REQ-033 Backpressure: out_ready toggles 1,0,0,1,... -> every word appears exactly once, in order, and is stable while stalled; in_ready stays 0 until idx=9.
REQ-034 Back-to-back: two frames with in_valid held high and out_ready=1 -> 20 consecutive valid words with no gap, and in_ready pulses only in the cycle with idx=9.
REQ-035 Reset mid-frame: assert rst after word 4 -> out_valid=0 immediately; after release, a new frame restarts at word 0 with no residue from the old frame.
REQ-036 Reference model check: 1000 random frames with random out_ready and in_valid -> the output stream equals the concatenation of frames, each word >> 1, with out_last on every tenth word.

Source files
------------

// File: rtl/frame_serializer_if.sv
// Handshake bundle between a frame producer, the serializer and a word consumer.
interface frame_serializer_if #(
    parameter int WORD_W = 100,
    parameter int NWORDS = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WORD_W*NWORDS-1:0] in_frame;
    logic                     out_valid;
    logic                     out_ready;
    logic [WORD_W-1:0]        out_word;
    logic                     out_last;
    logic                     busy;

    modport master (
        output in_valid, in_frame, out_ready,
        input  in_ready, out_valid, out_word, out_last, busy
    );

    modport slave (
        input  in_valid, in_frame, out_ready,
        output in_ready, out_valid, out_word, out_last, busy
    );
endinterface

// File: rtl/frame_serializer.sv
// Holds one wide frame and emits it word 0 first, one word per output
// transfer, undoing the upstream x2 scaling on each word.
module frame_serializer #(
    parameter int WORD_W = 100,
    parameter int NWORDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    frame_serializer_if.slave bus
);
    localparam int               IDX_W    = $clog2(NWORDS);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       SEND     = 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    logic [0:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [WORD_W*NWORDS-1:0] frame_p0;
    logic [WORD_W-1:0]        word_p0;
    logic                     vld_p0;
    logic                     last_p0;
    logic                     ready_in;
    logic                     take_in;
    logic                     take_out;

    // Logical shift right: the MSB is forced to zero, so a wrapped x2 value
    // comes back modulo 2^WORD_W rather than sign-extended.
    function automatic logic [WORD_W-1:0] descale(input logic [WORD_W-1:0] w);
        return {1'b0, w[WORD_W-1:1]};
    endfunction

    assign vld_p0   = (state == SEND);
    assign last_p0  = vld_p0 && (idx == IDX_LAST);
    assign word_p0  = frame_p0[WORD_W*(NWORDS-1-int'(idx)) +: WORD_W];
    // Accepting on the last word lets the next frame follow with no bubble.
    assign ready_in = !vld_p0 || (last_p0 && bus.out_ready);
    assign take_in  = bus.in_valid && ready_in;
    assign take_out = vld_p0 && bus.out_ready;

    assign bus.in_ready  = ready_in;
    assign bus.out_valid = vld_p0;
    assign bus.busy      = vld_p0;
    assign bus.out_last  = last_p0;
    assign bus.out_word  = descale(word_p0);

    // p0: held frame, word index and state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            frame_p0 <= '0;
        end else if (take_in) begin
            state    <= SEND;
            idx      <= '0;
            frame_p0 <= bus.in_frame;
        end else if (take_out) begin
            if (last_p0) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench: the driver queues the expected words of every accepted
// frame, a negedge monitor compares them against whatever the DUT presents.
module tb_frame_serializer;
    localparam int W = 100;
    localparam int N = 10;

    typedef logic [W*N-1:0] frame_t;
    typedef logic [W-1:0]   word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 0;
    int   pos = 0;
    logic [W:0] exp_q[$];

    frame_serializer_if #(.WORD_W(W), .NWORDS(N)) bus ();

    frame_serializer #(.WORD_W(W), .NWORDS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic frame_t pack(input word_t w[N]);
        frame_t f;
        f = '0;
        for (int k = 0; k < N; k++) f[(N-1-k)*W +: W] = w[k];
        return f;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_frame(input word_t w[N], input word_t e[N]);
        bit ok;
        ok = 1'b0;
        bus.in_frame = pack(w);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.in_ready && !rst) begin
                for (int k = 0; k < N; k++) exp_q.push_back({(k == N-1) ? 1'b1 : 1'b0, e[k]});
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("frame_accept", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        chk("drain", (exp_q.size() == 0 && !bus.out_valid) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: 0 = always high, 1 = pattern 1,0,0 repeating, 2 = random
    initial begin
        int c;
        c = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = (c % 3 == 0);
                2:       bus.out_ready = ($urandom_range(0, 1) == 1);
                default: bus.out_ready = 1'b1;
            endcase
            c++;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [W:0] e;
        logic       exp_inr;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pos = 0;
            end else begin
                exp_inr = bus.out_valid ? ((pos == N-1) ? bus.out_ready : 1'b0) : 1'b1;
                chk("in_ready", bus.in_ready, exp_inr);
                chk("busy", bus.busy, bus.out_valid);
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", bus.out_valid, 0);
                    end else begin
                        e = exp_q[0];
                        chk("out_word", bus.out_word, e[W-1:0]);
                        chk("out_last", bus.out_last, e[W]);
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            pos = (pos == N-1) ? 0 : pos + 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w[N];
        word_t e[N];
        word_t w2[N];
        word_t e2[N];
        logic [127:0] tmp;
        int gap;

        bus.in_valid = 1'b0;
        bus.in_frame = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_word", bus.out_word, 0);

        // Single frame right after reset release: words 2,4,..,20 -> 1..10
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            w[k] = word_t'(2 * (k + 1));
            e[k] = word_t'(k + 1);
        end
        send_frame(w, e);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_word", bus.out_word, 1);
        repeat (9) @(posedge clk);
        #1;
        chk("drain_last", bus.out_last, 1);
        chk("drain_word", bus.out_word, 10);
        @(posedge clk);
        #1;
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_in_ready", bus.in_ready, 1);
        wait_idle();

        // Wrap-around descale and all-ones word
        w[0] = 100'd6;
        w[0][99] = 1'b1;
        e[0] = 100'd3;
        e[0][98] = 1'b1;
        w[1] = '1;
        e[1] = {1'b0, {99{1'b1}}};
        for (int k = 2; k < N; k++) begin
            w[k] = word_t'(2 * k + 1);
            e[k] = word_t'(k);
        end
        send_frame(w, e);
        chk("wrap_msb", bus.out_word[W-1], 0);
        wait_idle();

        // Backpressure 1,0,0,...: words 100k -> 50k
        rdy_mode = 1;
        for (int k = 0; k < N; k++) begin
            w[k] = word_t'(100 * k);
            e[k] = word_t'(50 * k);
        end
        send_frame(w, e);
        wait_idle();
        rdy_mode = 0;

        // Back-to-back frames with in_valid kept high
        for (int k = 0; k < N; k++) begin
            w[k]  = word_t'(2 * (k + 1));
            e[k]  = word_t'(k + 1);
            w2[k] = word_t'(2 * (k + 21));
            e2[k] = word_t'(k + 21);
        end
        fork
            begin
                send_frame(w, e);
                send_frame(w2, e2);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                chk("b2b_start", bus.out_valid, 1);
                for (int i = 1; i < 2 * N; i++) begin
                    @(negedge clk);
                    chk("b2b_no_gap", bus.out_valid, 1);
                end
                @(negedge clk);
                chk("b2b_end", bus.out_valid, 0);
            end
        join
        wait_idle();

        // Reset mid-frame after words 0..4, then a fresh frame
        for (int k = 0; k < N; k++) begin
            w[k]  = word_t'(2 * (k + 11));
            e[k]  = word_t'(k + 11);
            w2[k] = word_t'(4 * k + 2);
            e2[k] = word_t'(2 * k + 1);
        end
        send_frame(w, e);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_out_last", bus.out_last, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(w2, e2);
        chk("mrst_restart_word", bus.out_word, 1);
        wait_idle();

        // Random frames, random gaps, random out_ready
        rdy_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            for (int k = 0; k < N; k++) begin
                tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
                w[k] = tmp[W-1:0];
                e[k] = w[k] >> 1;
            end
            send_frame(w, e);
        end
        rdy_mode = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
